// File: rtl/case_7_div_pkg.sv
// Shared types and constants for the case_7 sequential signed divider.
package case_7_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  localparam int DIN0_W = 9;
  localparam int DIN1_W = 6;
  localparam int DOUT_W = 9;

  localparam logic [DOUT_W-1:0] DIV0_QUOT = 9'h1FF;

endpackage

// File: rtl/case_7_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract, restore on borrow.
module case_7_div_step #(
  parameter int din1_WIDTH = 6
) (
  input  logic [din1_WIDTH:0]   rem_i,
  input  logic                  bit_i,
  input  logic [din1_WIDTH-1:0] dsr_i,
  output logic [din1_WIDTH:0]   rem_o,
  output logic                  q_o
);

  logic [din1_WIDTH+1:0] shift_s;
  logic [din1_WIDTH+1:0] diff_s;

  // Top bit of diff_s is the borrow; valid operands keep shift_s below 2*divisor.
  always_comb begin
    shift_s = {rem_i, bit_i};
    diff_s  = shift_s - {2'b00, dsr_i};
    if (diff_s[din1_WIDTH+1]) begin
      rem_o = shift_s[din1_WIDTH:0];
      q_o   = 1'b0;
    end else begin
      rem_o = diff_s[din1_WIDTH:0];
      q_o   = 1'b1;
    end
  end

endmodule

// File: rtl/case_7_sdiv_9s_6s_9_seq.sv
// Multi-cycle signed divider: magnitudes through restoring division, then sign fix-up.
module case_7_sdiv_9s_6s_9_seq
  import case_7_div_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(din0_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(din0_WIDTH - 1);

  div_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [din0_WIDTH-1:0] dvd_q, dvd_d;
  logic [din1_WIDTH:0]   prem_q, prem_d;
  logic [din1_WIDTH-1:0] dsr_q, dsr_d;
  logic [din1_WIDTH-1:0] lo_q, lo_d;
  logic                  sign0_q, sign0_d;
  logic                  sign1_q, sign1_d;
  logic                  zero_q, zero_d;
  logic [dout_WIDTH-1:0] dout_q, dout_d;
  logic [din1_WIDTH-1:0] rem_q, rem_d;
  logic                  dbz_q, dbz_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;

  logic [din1_WIDTH:0]   step_rem_s;
  logic                  step_q_s;

  case_7_div_step #(.din1_WIDTH(din1_WIDTH)) u_step (
    .rem_i (prem_q),
    .bit_i (dvd_q[din0_WIDTH-1]),
    .dsr_i (dsr_q),
    .rem_o (step_rem_s),
    .q_o   (step_q_s)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    prem_d      = prem_q;
    dsr_d       = dsr_q;
    lo_d        = lo_q;
    sign0_d     = sign0_q;
    sign1_d     = sign1_q;
    zero_d      = zero_q;
    dout_d      = dout_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d      = din0[din0_WIDTH-1] ? -din0 : din0;
          dsr_d      = din1[din1_WIDTH-1] ? -din1 : din1;
          lo_d       = din0[din1_WIDTH-1:0];
          sign0_d    = din0[din0_WIDTH-1];
          sign1_d    = din1[din1_WIDTH-1];
          zero_d     = (din1 == '0);
          prem_d     = '0;
          cnt_d      = CNT_LAST;
          in_ready_d = 1'b0;
          state_d    = S_CALC;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_CALC: begin
        // Quotient bits enter the LSB as dividend bits leave the MSB.
        dvd_d  = {dvd_q[din0_WIDTH-2:0], step_q_s};
        prem_d = step_rem_s;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        if (zero_q) begin
          dout_d = DIV0_QUOT;
          rem_d  = lo_q;
          dbz_d  = 1'b1;
        end else begin
          dout_d = (sign0_q ^ sign1_q) ? -dvd_q : dvd_q;
          rem_d  = sign0_q ? -prem_q[din1_WIDTH-1:0] : prem_q[din1_WIDTH-1:0];
          dbz_d  = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      prem_q      <= '0;
      dsr_q       <= '0;
      lo_q        <= '0;
      sign0_q     <= 1'b0;
      sign1_q     <= 1'b0;
      zero_q      <= 1'b0;
      dout_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      prem_q      <= prem_d;
      dsr_q       <= dsr_d;
      lo_q        <= lo_d;
      sign0_q     <= sign0_d;
      sign1_q     <= sign1_d;
      zero_q      <= zero_d;
      dout_q      <= dout_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign dout        = dout_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule
